udp_encoder_buf: RTL and testbench
==================================

Name: udp_encoder_buf

Overview:
Store-and-forward UDP encoder, successor to the streaming UDP encoder. It buffers up to DEPTH 32-bit payload words and computes the full RFC 768 checksum (IPv4 pseudo-header + UDP header + payload). It then emits a complete UDP segment, header first with the final checksum in place, followed by the payload. It sits between the application data source and the IP encoder write FIFO. It adds byte-accurate padding masking, a length error check and output back-pressure.

Parameters:
DEPTH, 16, payload buffer depth in 32-bit words; max payload = 4*DEPTH bytes
PROTO, 8'h11, protocol byte used in the pseudo-header
ADDR_W, $clog2(DEPTH), derived buffer address width; not overridden

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low (0 = reset)
src_ip  in  32  source IPv4 address, sampled on accepted start
dest_ip  in  32  destination IPv4 address, sampled on accepted start
src_port  in  16  source port, sampled on accepted start
dest_port  in  16  destination port, sampled on accepted start
len_in  in  16  payload length in bytes, sampled on accepted start
no_chksum  in  1  1 = transmit checksum 0x0000; sampled on accepted start
start  in  1  begin packet; accepted only in IDLE
data  in  32  payload word, big-endian (byte 0 in [31:24])
data_av  in  1  data word valid
full  in  1  downstream FIFO full; stalls emission
ready  out  1  1 in IDLE and COLLECT (input accepted)
pkg_data  out  32  output segment word
wr_en  out  1  pkg_data valid and written this cycle
fin  out  1  1 with the last word of the segment
checksum_out  out  16  final checksum, valid from FOLD exit until next accepted start
len_out  out  16  UDP length (len_in+8), same validity as checksum_out
err  out  1  one-cycle pulse: len_in > 4*DEPTH, start rejected

Behaviour:
- Reset (reset=0 at clk edge): state IDLE. pkg_data, wr_en, fin, checksum_out, len_out and err are 0; ready=1. Buffer contents are don't-care. Reset mid-packet aborts the packet with no further wr_en.
- nwords = ceil(len_in/4). udp_len = len_in+8, truncated to 16 bits.
- IDLE:
  - start=1 with len_in > 4*DEPTH: err=1 for 1 cycle; remain IDLE.
  - Otherwise: latch fields, clear the accumulator, seed it with src_ip[31:16], src_ip[15:0], dest_ip halves, {8'h0,PROTO}, udp_len*2, src_port, dest_port.
  - If data_av=1 in the start cycle, that word is word 0.
  - nwords=0: go to FOLD; else go to COLLECT.
- COLLECT: each data_av=1 cycle stores one word at the write pointer. Bytes beyond len_in in the last word are masked to 0x00 before both storage and summation. Each stored word adds its two 16-bit halves to a 32-bit accumulator. After word nwords-1, go to FOLD. start is ignored while not IDLE.
- FOLD: 2 cycles.
  - Cycle 1: acc = acc[15:0] + acc[31:16].
  - Cycle 2: same again, then cs = ~acc[15:0].
  - If cs==0x0000, substitute 0xFFFF. If no_chksum, cs = 0x0000.
  - Register checksum_out=cs and len_out=udp_len, then go to EMIT.
- EMIT: word sequence is {src_port,dest_port}, {udp_len,cs}, then buffer words 0..nwords-1.
  - wr_en = (state==EMIT) & ~full.
  - The index advances only when wr_en=1. pkg_data holds stable while full=1.
  - fin = wr_en on the final word. Go to IDLE the following cycle.
- Latency: first header word appears 3 cycles after the last payload word is accepted, if full=0. Output is 2+nwords words.
- Simultaneous reset=0 and start=1: reset wins.

Decomposition:
- Package udp_pkg: state encoding (IDLE, COLLECT, FOLD1, FOLD2, EMIT), UDP_HDR_BYTES=8, PROTO_UDP=8'h11, and a one's-complement add function.
- Sub-module udp_payload_buf: DEPTH x 32 simple dual-port register array with synchronous write and combinational read.

Test Plan:
1. src_ip=1, dest_ip=2, ports 0xA08F/0x2694, len_in=11, "Hello World" in 3 words (start+data_av together) -> words 0xA08F2694, 0x0013E6D3, 0x48656C6C, 0x6F20576F, 0x726C6400 on consecutive cycles; fin on the 5th; checksum_out=0xE6D3; len_out=0x0013.
2. Same as 1 but last data word 0x726C64FF and a 1-cycle data_av gap -> output identical to 1 (padding masked, gap tolerated).
3. Same as 1 with no_chksum=1 -> second word 0x00130000; checksum_out=0x0000.
4. len_in=0, same addresses and ports -> 2 words: 0xA08F2694, 0x000838B8; fin on the 2nd.
5. DEPTH=16, len_in=65 -> err pulse for 1 cycle; wr_en never asserted; next valid start accepted.
6. Scenario 1 with full=1 for 3 cycles during payload word 1, then reset=0 asserted during the next packet's COLLECT -> no word lost or duplicated, and pkg_data stable while stalled. After the reset: all outputs 0 the next cycle and no wr_en; a subsequent packet matches scenario 1.

Source files
------------

// File: rtl/udp_pkg.sv
// Shared types and helpers for the store-and-forward UDP encoder.
// Holds the FSM encoding, protocol constants and one's-complement arithmetic.
package udp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        FOLD1,
        FOLD2,
        EMIT
    } udp_state_t;

    localparam int         UDP_HDR_BYTES = 8;
    localparam logic [7:0] PROTO_UDP     = 8'h11;

    function automatic logic [15:0] ones_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'h0, s[16]};
    endfunction

    // Keeps only the valid leading bytes of a big-endian word; rem==0 means all four.
    function automatic logic [31:0] pad_mask(input logic [1:0] rem);
        case (rem)
            2'd1:    return 32'hFF00_0000;
            2'd2:    return 32'hFFFF_0000;
            2'd3:    return 32'hFFFF_FF00;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/udp_payload_buf.sv
// Payload word store: synchronous write, combinational read.
// Contents carry no reset; every read location is written before it is emitted.
module udp_payload_buf #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [31:0]       wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/udp_encoder_buf.sv
// Store-and-forward UDP encoder: buffers the payload, folds the RFC 768 checksum,
// then emits header (with final checksum) followed by the payload under back-pressure.
module udp_encoder_buf
    import udp_pkg::*;
#(
    parameter int         DEPTH  = 16,
    parameter logic [7:0] PROTO  = PROTO_UDP,
    parameter int         ADDR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] src_ip,
    input  logic [31:0] dest_ip,
    input  logic [15:0] src_port,
    input  logic [15:0] dest_port,
    input  logic [15:0] len_in,
    input  logic        no_chksum,
    input  logic        start,
    input  logic [31:0] data,
    input  logic        data_av,
    input  logic        full,
    output logic        ready,
    output logic [31:0] pkg_data,
    output logic        wr_en,
    output logic        fin,
    output logic [15:0] checksum_out,
    output logic [15:0] len_out,
    output logic        err
);

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [ADDR_W:0]   nw_t;
    typedef logic [ADDR_W+1:0] idx_t;

    localparam logic [16:0] MAX_LEN = 17'(4 * DEPTH);

    udp_state_t  state_q, state_d;
    logic [31:0] acc_q, acc_d;
    addr_t       wptr_q, wptr_d;
    idx_t        idx_q, idx_d;
    nw_t         nwords_q, nwords_d;
    logic [1:0]  rem_q, rem_d;
    logic [15:0] sport_q, sport_d, dport_q, dport_d, ulen_q, ulen_d;
    logic        nock_q, nock_d;
    logic [15:0] cs_q, cs_d, lenout_q, lenout_d;
    logic        err_q, err_d;

    logic        buf_we;
    addr_t       buf_waddr, buf_raddr;
    logic [31:0] buf_rdata;

    logic        len_bad, last_wr;
    logic [15:0] ulen_in, fold_sum, cs_calc;
    logic [1:0]  cur_rem;
    nw_t         nw_in, cur_nw;
    logic [31:0] wdata_m, word_sum, seed;

    assign len_bad  = {1'b0, len_in} > MAX_LEN;
    assign ulen_in  = len_in + 16'(UDP_HDR_BYTES);
    assign nw_in    = nw_t'(len_in[ADDR_W+2:2]) + nw_t'(|len_in[1:0]);
    assign cur_nw   = (state_q == IDLE) ? nw_in : nwords_q;
    assign cur_rem  = (state_q == IDLE) ? len_in[1:0] : rem_q;
    assign last_wr  = ({1'b0, buf_waddr} == (cur_nw - nw_t'(1)));
    assign wdata_m  = last_wr ? (data & pad_mask(cur_rem)) : data;
    assign word_sum = 32'(wdata_m[31:16]) + 32'(wdata_m[15:0]);
    // udp_len appears twice in the sum: once in the pseudo-header, once in the UDP header.
    assign seed     = 32'(src_ip[31:16]) + 32'(src_ip[15:0]) + 32'(dest_ip[31:16])
                    + 32'(dest_ip[15:0]) + 32'({8'h00, PROTO}) + {15'h0, ulen_in, 1'b0}
                    + 32'(src_port) + 32'(dest_port);
    assign fold_sum = ones_add16(acc_q[15:0], acc_q[31:16]);
    assign cs_calc  = ~fold_sum;

    assign buf_waddr = (state_q == IDLE) ? addr_t'(0) : wptr_q;
    assign buf_raddr = idx_q[ADDR_W-1:0] - addr_t'(2);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        wptr_d   = wptr_q;
        idx_d    = idx_q;
        nwords_d = nwords_q;
        rem_d    = rem_q;
        sport_d  = sport_q;
        dport_d  = dport_q;
        ulen_d   = ulen_q;
        nock_d   = nock_q;
        cs_d     = cs_q;
        lenout_d = lenout_q;
        err_d    = 1'b0;
        buf_we   = 1'b0;
        wr_en    = 1'b0;
        fin      = 1'b0;
        pkg_data = 32'h0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len_bad) begin
                        err_d = 1'b1;
                    end else begin
                        sport_d  = src_port;
                        dport_d  = dest_port;
                        ulen_d   = ulen_in;
                        nock_d   = no_chksum;
                        nwords_d = nw_in;
                        rem_d    = len_in[1:0];
                        acc_d    = seed;
                        wptr_d   = addr_t'(0);
                        if (nw_in == nw_t'(0)) begin
                            state_d = FOLD1;
                        end else if (data_av) begin
                            buf_we  = 1'b1;
                            acc_d   = seed + word_sum;
                            wptr_d  = addr_t'(1);
                            state_d = last_wr ? FOLD1 : COLLECT;
                        end else begin
                            state_d = COLLECT;
                        end
                    end
                end
            end
            COLLECT: begin
                if (data_av) begin
                    buf_we = 1'b1;
                    acc_d  = acc_q + word_sum;
                    wptr_d = wptr_q + addr_t'(1);
                    if (last_wr) state_d = FOLD1;
                end
            end
            FOLD1: begin
                acc_d   = 32'(acc_q[15:0]) + 32'(acc_q[31:16]);
                state_d = FOLD2;
            end
            FOLD2: begin
                cs_d     = nock_q ? 16'h0000 : ((cs_calc == 16'h0000) ? 16'hFFFF : cs_calc);
                lenout_d = ulen_q;
                idx_d    = idx_t'(0);
                state_d  = EMIT;
            end
            EMIT: begin
                wr_en = ~full;
                if (idx_q == idx_t'(0))      pkg_data = {sport_q, dport_q};
                else if (idx_q == idx_t'(1)) pkg_data = {ulen_q, cs_q};
                else                         pkg_data = buf_rdata;
                if (!full) begin
                    if (idx_q == idx_t'(nwords_q) + idx_t'(1)) begin
                        fin     = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + idx_t'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            wptr_q   <= '0;
            idx_q    <= '0;
            cs_q     <= '0;
            lenout_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wptr_q   <= wptr_d;
            idx_q    <= idx_d;
            cs_q     <= cs_d;
            lenout_q <= lenout_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        acc_q    <= acc_d;
        nwords_q <= nwords_d;
        rem_q    <= rem_d;
        sport_q  <= sport_d;
        dport_q  <= dport_d;
        ulen_q   <= ulen_d;
        nock_q   <= nock_d;
    end

    udp_payload_buf #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk     (clk),
        .we_i    (buf_we),
        .waddr_i (buf_waddr),
        .wdata_i (wdata_m),
        .raddr_i (buf_raddr),
        .rdata_o (buf_rdata)
    );

    assign ready        = (state_q == IDLE) || (state_q == COLLECT);
    assign checksum_out = cs_q;
    assign len_out      = lenout_q;
    assign err          = err_q;

endmodule

// File: tb/tb_udp_encoder_buf.sv
// Directed bench for udp_encoder_buf using the "Hello World" reference segment.
module tb_udp_encoder_buf;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] src_ip = 32'h1, dest_ip = 32'h2;
    logic [15:0] src_port = 16'hA08F, dest_port = 16'h2694, len_in = 16'h0;
    logic        no_chksum = 1'b0, start = 1'b0, data_av = 1'b0, full = 1'b0;
    logic [31:0] data = 32'h0;
    logic        ready, wr_en, fin, err;
    logic [31:0] pkg_data;
    logic [15:0] checksum_out, len_out;

    localparam logic [31:0] HW0 = 32'h4865_6C6C, HW1 = 32'h6F20_576F, HW2 = 32'h726C_6400;
    logic [31:0] exp1 [5] = '{32'hA08F_2694, 32'h0013_E6D3, HW0, HW1, HW2};
    logic [31:0] exp3 [5] = '{32'hA08F_2694, 32'h0013_0000, HW0, HW1, HW2};

    int n_pass = 0, n_tot = 0, cyc = 0, last_cyc = 0;
    logic [31:0] capq [$];
    logic        finq [$];
    int          capc [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            capq.push_back(pkg_data);
            finq.push_back(fin);
            capc.push_back(cyc);
        end
    end

    udp_encoder_buf dut (
        .clk(clk), .reset(reset), .src_ip(src_ip), .dest_ip(dest_ip),
        .src_port(src_port), .dest_port(dest_port), .len_in(len_in),
        .no_chksum(no_chksum), .start(start), .data(data), .data_av(data_av),
        .full(full), .ready(ready), .pkg_data(pkg_data), .wr_en(wr_en), .fin(fin),
        .checksum_out(checksum_out), .len_out(len_out), .err(err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cap();
        capq.delete();
        finq.delete();
        capc.delete();
    endtask

    task automatic wait_fin(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (finq.size() > 0 && finq[finq.size()-1] === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    // Sends the 11-byte payload; gap inserts an idle cycle before the last word.
    task automatic send_hello(input logic nock, input logic [31:0] last_word, input bit gap);
        clear_cap();
        step();
        start = 1'b1; len_in = 16'd11; no_chksum = nock; data_av = 1'b1; data = HW0;
        step();
        start = 1'b0; data = HW1;
        step();
        if (gap) begin
            data_av = 1'b0;
            step();
            data_av = 1'b1;
        end
        data = last_word; last_cyc = cyc;
        step();
        data_av = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b1; len_in = 16'd11;
        step();
        step();
        @(negedge clk);
        n_tot++; if (ready !== 1'b1) $display("FAIL rst_ready got %b want 1", ready); else n_pass++;
        n_tot++; if (wr_en !== 1'b0) $display("FAIL rst_wr_en got %b want 0", wr_en); else n_pass++;
        n_tot++; if (fin !== 1'b0) $display("FAIL rst_fin got %b want 0", fin); else n_pass++;
        n_tot++; if (pkg_data !== 32'h0) $display("FAIL rst_pkg_data got %h want 0", pkg_data); else n_pass++;
        n_tot++; if (checksum_out !== 16'h0) $display("FAIL rst_cs got %h want 0", checksum_out); else n_pass++;
        n_tot++; if (len_out !== 16'h0) $display("FAIL rst_len got %h want 0", len_out); else n_pass++;
        n_tot++; if (err !== 1'b0) $display("FAIL rst_err got %b want 0", err); else n_pass++;
        step();
        start = 1'b0; reset = 1'b1;
        step();
    endtask

    task automatic test_basic();
        bit ok;
        send_hello(1'b0, HW2, 1'b0);
        wait_fin(ok);
        n_tot++; if (!ok) $display("FAIL basic_timeout got no fin want fin"); else n_pass++;
        n_tot++; if (capq.size() != 5) $display("FAIL basic_count got %0d want 5", capq.size()); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            n_tot++;
            if (i >= capq.size()) $display("FAIL basic_word%0d got none want %h", i, exp1[i]);
            else if (capq[i] !== exp1[i]) $display("FAIL basic_word%0d got %h want %h", i, capq[i], exp1[i]);
            else n_pass++;
        end
        if (capq.size() == 5) begin
            n_tot++; if (capc[0] != last_cyc + 3) $display("FAIL basic_latency got %0d want %0d", capc[0] - last_cyc, 3); else n_pass++;
            n_tot++; if (capc[4] - capc[0] != 4) $display("FAIL basic_consecutive got %0d want 4", capc[4] - capc[0]); else n_pass++;
            n_tot++; if (finq[4] !== 1'b1 || finq[3] !== 1'b0) $display("FAIL basic_fin got %b%b want 01", finq[3], finq[4]); else n_pass++;
        end
        @(negedge clk);
        n_tot++; if (checksum_out !== 16'hE6D3) $display("FAIL basic_cs got %h want e6d3", checksum_out); else n_pass++;
        n_tot++; if (len_out !== 16'h0013) $display("FAIL basic_len got %h want 0013", len_out); else n_pass++;
        n_tot++; if (ready !== 1'b1) $display("FAIL basic_idle_ready got %b want 1", ready); else n_pass++;
    endtask

    task automatic test_pad_gap();
        bit ok;
        send_hello(1'b0, 32'h726C_64FF, 1'b1);
        wait_fin(ok);
        n_tot++; if (!ok || capq.size() != 5) $display("FAIL pad_count got %0d want 5", capq.size()); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            n_tot++;
            if (i >= capq.size()) $display("FAIL pad_word%0d got none want %h", i, exp1[i]);
            else if (capq[i] !== exp1[i]) $display("FAIL pad_word%0d got %h want %h", i, capq[i], exp1[i]);
            else n_pass++;
        end
    endtask

    task automatic test_no_chksum();
        bit ok;
        send_hello(1'b1, HW2, 1'b0);
        wait_fin(ok);
        n_tot++; if (!ok || capq.size() != 5) $display("FAIL nock_count got %0d want 5", capq.size()); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            n_tot++;
            if (i >= capq.size()) $display("FAIL nock_word%0d got none want %h", i, exp3[i]);
            else if (capq[i] !== exp3[i]) $display("FAIL nock_word%0d got %h want %h", i, capq[i], exp3[i]);
            else n_pass++;
        end
        @(negedge clk);
        n_tot++; if (checksum_out !== 16'h0000) $display("FAIL nock_cs got %h want 0000", checksum_out); else n_pass++;
        no_chksum = 1'b0;
    endtask

    task automatic test_len_err();
        clear_cap();
        step();
        start = 1'b1; len_in = 16'd65;
        step();
        start = 1'b0;
        @(negedge clk);
        n_tot++; if (err !== 1'b1) $display("FAIL lenerr_pulse got %b want 1", err); else n_pass++;
        n_tot++; if (ready !== 1'b1) $display("FAIL lenerr_ready got %b want 1", ready); else n_pass++;
        step();
        @(negedge clk);
        n_tot++; if (err !== 1'b0) $display("FAIL lenerr_clear got %b want 0", err); else n_pass++;
        repeat (6) step();
        n_tot++; if (capq.size() != 0) $display("FAIL lenerr_wr_en got %0d words want 0", capq.size()); else n_pass++;
    endtask

    task automatic test_zero_len();
        bit ok;
        clear_cap();
        step();
        start = 1'b1; len_in = 16'd0; data_av = 1'b0;
        step();
        start = 1'b0;
        wait_fin(ok);
        n_tot++; if (!ok || capq.size() != 2) $display("FAIL zero_count got %0d want 2", capq.size()); else n_pass++;
        if (capq.size() == 2) begin
            n_tot++; if (capq[0] !== 32'hA08F_2694) $display("FAIL zero_word0 got %h want a08f2694", capq[0]); else n_pass++;
            n_tot++; if (capq[1] !== 32'h0008_38B8) $display("FAIL zero_word1 got %h want 000838b8", capq[1]); else n_pass++;
            n_tot++; if (finq[1] !== 1'b1 || finq[0] !== 1'b0) $display("FAIL zero_fin got %b%b want 01", finq[0], finq[1]); else n_pass++;
        end
        @(negedge clk);
        n_tot++; if (len_out !== 16'h0008) $display("FAIL zero_len got %h want 0008", len_out); else n_pass++;
    endtask

    task automatic test_stall_reset();
        bit ok;
        send_hello(1'b0, HW2, 1'b0);
        for (int i = 0; i < 20 && capq.size() < 3; i++) step();
        full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tot++; if (wr_en !== 1'b0) $display("FAIL stall_wr_en%0d got %b want 0", i, wr_en); else n_pass++;
            n_tot++; if (pkg_data !== HW1) $display("FAIL stall_hold%0d got %h want %h", i, pkg_data, HW1); else n_pass++;
            step();
        end
        full = 1'b0;
        wait_fin(ok);
        n_tot++; if (!ok || capq.size() != 5) $display("FAIL stall_count got %0d want 5", capq.size()); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            n_tot++;
            if (i >= capq.size()) $display("FAIL stall_word%0d got none want %h", i, exp1[i]);
            else if (capq[i] !== exp1[i]) $display("FAIL stall_word%0d got %h want %h", i, capq[i], exp1[i]);
            else n_pass++;
        end
        clear_cap();
        step();
        start = 1'b1; len_in = 16'd11; data_av = 1'b1; data = HW0;
        step();
        start = 1'b0; data = HW1;
        step();
        data_av = 1'b0; reset = 1'b0;
        step();
        @(negedge clk);
        n_tot++; if (wr_en !== 1'b0 || fin !== 1'b0 || err !== 1'b0) $display("FAIL abort_ctl got %b%b%b want 000", wr_en, fin, err); else n_pass++;
        n_tot++; if (pkg_data !== 32'h0) $display("FAIL abort_data got %h want 0", pkg_data); else n_pass++;
        n_tot++; if (checksum_out !== 16'h0 || len_out !== 16'h0) $display("FAIL abort_cs_len got %h/%h want 0/0", checksum_out, len_out); else n_pass++;
        n_tot++; if (ready !== 1'b1) $display("FAIL abort_ready got %b want 1", ready); else n_pass++;
        reset = 1'b1;
        repeat (8) step();
        n_tot++; if (capq.size() != 0) $display("FAIL abort_no_wr got %0d words want 0", capq.size()); else n_pass++;
        test_basic();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pad_gap();
        test_no_chksum();
        test_len_err();
        test_zero_len();
        test_stall_reset();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
